// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and default geometry for the block data memory
package dmem_pkg;
  localparam int DMEM_ADDR_W = 6;
  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: cache-to-memory word bus (master = cache, slave = memory)
// read/write/address/writedata flow to memory; readdata/busywait flow back.
interface dmem_if import dmem_pkg::*; #(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int WORD_W = DMEM_WORD_W
);
  logic read;
  logic write;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] writedata;
  logic [WORD_W-1:0] readdata;
  logic busywait;
  modport master (output read, write, address, writedata, input readdata, busywait);
  modport slave (input read, write, address, writedata, output readdata, busywait);
endinterface

// File: rtl/dmem_latency_ctr.sv
// dmem_latency_ctr: loadable down-counter with zero flag timing the access latency
// Ports: clock, reset, load/load_val (preset), en (count down), zero (count is 0).
module dmem_latency_ctr import dmem_pkg::*; #(
  parameter int W = DMEM_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic [W-1:0] load_val,
  output logic zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock)
    cnt <= reset ? '0 : load ? load_val : (en && !zero) ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/dmem_block.sv
// dmem_block: multi-cycle word data memory behind the data cache, busywait-stalled
// Ports: clock, reset (sync, active-high), bus (dmem_if.slave); with DMEM_STATS_EN
// defined, rd_count/wr_count report saturating counts of committed reads/writes.
module dmem_block import dmem_pkg::*; #(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int WORD_W = DMEM_WORD_W,
  parameter int LATENCY = 5
) (
  input  logic clock,
  input  logic reset,
  dmem_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);
  state_t state, state_n;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q, rdata_q;
  logic wr_q, req, start, zero, commit;
  assign req = bus.read | bus.write;
  assign start = state == IDLE && req;
  assign commit = state == BUSY && zero;
  // busywait rises combinationally with the request so the cache stalls at its next edge
  assign bus.busywait = start || state == BUSY;
  assign bus.readdata = rdata_q;
  // DONE always falls back to IDLE, giving the cache one cycle to drop its request
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (req ? BUSY : IDLE) : state == BUSY ? (zero ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  dmem_latency_ctr #(.W(DMEM_CNT_W)) u_ctr (
    .clock(clock),
    .reset(reset),
    .load(start),
    .en(state == BUSY),
    .load_val(DMEM_CNT_W'(LATENCY - 1)),
    .zero(zero)
  );
  // request is latched at acceptance; write wins when read and write are both high
  always_ff @(posedge clock)
    if (reset) begin
      rdata_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else begin
      if (start) begin
        wr_q <= bus.write;
        addr_q <= bus.address;
        data_q <= bus.writedata;
      end
      if (commit && wr_q) mem[addr_q] <= data_q;
      if (commit && !wr_q) rdata_q <= mem[addr_q];
    end
`ifdef DMEM_STATS_EN
  always_ff @(posedge clock) begin
    rd_count <= reset ? '0 : (commit && !wr_q && rd_count != '1) ? rd_count + 1'b1 : rd_count;
    wr_count <= reset ? '0 : (commit && wr_q && wr_count != '1) ? wr_count + 1'b1 : wr_count;
  end
`endif
endmodule
